// File: rtl/ram_write_serializer_pkg.sv
// Shared constants and write-request record for the RAM write serializer.
package ram_write_serializer_pkg;

   localparam int unsigned DEPTH_DEF  = 16;
   localparam int unsigned INDEX_DEF  = 4;
   localparam int unsigned WIDTH_DEF  = 8;
   localparam int unsigned QDEPTH_DEF = 8;
   localparam int unsigned QINDEX_DEF = 3;

   typedef struct packed {
      logic [INDEX_DEF-1:0] addr;
      logic [WIDTH_DEF-1:0] data;
   } wr_req_t;

endpackage

// File: rtl/ram_write_serializer_compact4.sv
// Compacts up to four valid requests: per-port slot offset plus total count.
module write_compact4 (
   input  logic [3:0] valid,
   output logic [2:0] count,
   output logic [1:0] offset0,
   output logic [1:0] offset1,
   output logic [1:0] offset2,
   output logic [1:0] offset3
);

   logic [1:0] off [4];
   logic [2:0] run;

   always_comb begin
      run = '0;
      for (int unsigned p = 0; p < 4; p++) begin
         off[p] = run[1:0];
         run    = run + {2'b00, valid[p]};
      end
      count = run;
   end

   assign offset0 = off[0];
   assign offset1 = off[1];
   assign offset2 = off[2];
   assign offset3 = off[3];

endmodule

// File: rtl/ram_write_serializer.sv
// Four-port write queue draining one entry per cycle into a single RAM write
// port, with youngest-match forwarding lookup over pending entries.
module ram_write_serializer
   import ram_write_serializer_pkg::*;
#(
   parameter int unsigned DEPTH  = DEPTH_DEF,
   parameter int unsigned INDEX  = INDEX_DEF,
   parameter int unsigned WIDTH  = WIDTH_DEF,
   parameter int unsigned QDEPTH = QDEPTH_DEF,
   parameter int unsigned QINDEX = QINDEX_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wrValid0_i,
   input  logic              wrValid1_i,
   input  logic              wrValid2_i,
   input  logic              wrValid3_i,
   input  logic [INDEX-1:0]  wrAddr0_i,
   input  logic [INDEX-1:0]  wrAddr1_i,
   input  logic [INDEX-1:0]  wrAddr2_i,
   input  logic [INDEX-1:0]  wrAddr3_i,
   input  logic [WIDTH-1:0]  wrData0_i,
   input  logic [WIDTH-1:0]  wrData1_i,
   input  logic [WIDTH-1:0]  wrData2_i,
   input  logic [WIDTH-1:0]  wrData3_i,
   output logic              wrReady_o,
   output logic [INDEX-1:0]  ramAddrWr_o,
   output logic              ramWe_o,
   output logic [WIDTH-1:0]  ramDataWr_o,
   input  logic [INDEX-1:0]  lookupAddr_i,
   output logic              lookupHit_o,
   output logic [WIDTH-1:0]  lookupData_o,
   output logic [QINDEX:0]   occupancy_o,
   output logic              empty_o
);

   if (DEPTH > (2 ** INDEX) || QDEPTH != (2 ** QINDEX) || QDEPTH < 4) begin : g_bad_params
      $error("ram_write_serializer: inconsistent DEPTH/INDEX or QDEPTH/QINDEX");
   end

   wr_req_t           req [4];
   logic [3:0]        valid;
   logic [2:0]        count;
   logic [1:0]        off [4];
   wr_req_t           mem [QDEPTH];
   logic [QINDEX-1:0] head;
   logic [QINDEX-1:0] tail;
   logic [QINDEX:0]   occupancy;
   logic              accept;
   logic              deq;

   always_comb begin
      valid    = {wrValid3_i, wrValid2_i, wrValid1_i, wrValid0_i};
      req[0]   = '{addr: wrAddr0_i, data: wrData0_i};
      req[1]   = '{addr: wrAddr1_i, data: wrData1_i};
      req[2]   = '{addr: wrAddr2_i, data: wrData2_i};
      req[3]   = '{addr: wrAddr3_i, data: wrData3_i};
   end

   write_compact4 u_compact (
      .valid   (valid),
      .count   (count),
      .offset0 (off[0]),
      .offset1 (off[1]),
      .offset2 (off[2]),
      .offset3 (off[3])
   );

   // Readiness uses start-of-cycle occupancy; the concurrent drain is not credited.
   assign wrReady_o   = (occupancy <= (QINDEX+1)'(QDEPTH - 4));
   assign accept      = wrReady_o;
   assign empty_o     = (occupancy == '0);
   assign deq         = !empty_o;
   assign occupancy_o = occupancy;
   assign ramWe_o     = deq;
   assign ramAddrWr_o = deq ? mem[head].addr : '0;
   assign ramDataWr_o = deq ? mem[head].data : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         head      <= '0;
         tail      <= '0;
         occupancy <= '0;
      end else begin
         head      <= head + QINDEX'(deq);
         tail      <= tail + (accept ? QINDEX'(count) : '0);
         occupancy <= occupancy + (accept ? (QINDEX+1)'(count) : '0) - (QINDEX+1)'(deq);
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned p = 0; p < 4; p++) begin
         if (!reset && accept && valid[p]) begin
            mem[tail + QINDEX'(off[p])] <= req[p];
         end
      end
   end

   // Scan oldest to youngest so the last match found is the youngest.
   always_comb begin
      lookupHit_o  = 1'b0;
      lookupData_o = '0;
      for (int unsigned k = 0; k < QDEPTH; k++) begin
         if (((QINDEX+1)'(k) < occupancy) && (mem[head + QINDEX'(k)].addr == lookupAddr_i)) begin
            lookupHit_o  = 1'b1;
            lookupData_o = mem[head + QINDEX'(k)].data;
         end
      end
   end

endmodule

// File: tb/tb_ram_write_serializer.sv
// Self-checking bench for ram_write_serializer against a queue-based reference model.
module tb_ram_write_serializer;

   typedef struct {
      int unsigned addr;
      int unsigned data;
   } entry_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  va;
   logic [3:0]  aa [4];
   logic [7:0]  da [4];
   logic [3:0]  lookup_addr;
   logic        wr_ready, ram_we, lookup_hit, empty;
   logic [3:0]  ram_addr;
   logic [7:0]  ram_data, lookup_data;
   logic [3:0]  occupancy;

   entry_t      q [$];
   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   always #5 clk = ~clk;

   ram_write_serializer #(.DEPTH(16), .INDEX(4), .WIDTH(8), .QDEPTH(8), .QINDEX(3)) dut (
      .clk          (clk),
      .reset        (reset),
      .wrValid0_i   (va[0]),
      .wrValid1_i   (va[1]),
      .wrValid2_i   (va[2]),
      .wrValid3_i   (va[3]),
      .wrAddr0_i    (aa[0]),
      .wrAddr1_i    (aa[1]),
      .wrAddr2_i    (aa[2]),
      .wrAddr3_i    (aa[3]),
      .wrData0_i    (da[0]),
      .wrData1_i    (da[1]),
      .wrData2_i    (da[2]),
      .wrData3_i    (da[3]),
      .wrReady_o    (wr_ready),
      .ramAddrWr_o  (ram_addr),
      .ramWe_o      (ram_we),
      .ramDataWr_o  (ram_data),
      .lookupAddr_i (lookup_addr),
      .lookupHit_o  (lookup_hit),
      .lookupData_o (lookup_data),
      .occupancy_o  (occupancy),
      .empty_o      (empty)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // One clock cycle: drive inputs, compare all outputs with the model, then
   // advance the model exactly as the queue rules dictate.
   task automatic step(input logic rst, input logic [3:0] v, input logic [15:0] a,
                       input logic [31:0] d, input logic [3:0] lk, input bit chk);
      int unsigned exp_ready, exp_hit, exp_ldata;
      reset       = rst;
      va          = v;
      lookup_addr = lk;
      for (int p = 0; p < 4; p++) begin
         aa[p] = a[p*4 +: 4];
         da[p] = d[p*8 +: 8];
      end
      #1;
      exp_ready = ((8 - q.size()) >= 4) ? 1 : 0;
      exp_hit   = 0;
      exp_ldata = 0;
      for (int i = q.size() - 1; i >= 0; i--) begin
         if (q[i].addr == 32'(lk)) begin
            exp_hit   = 1;
            exp_ldata = q[i].data;
            break;
         end
      end
      if (chk) begin
         check("occupancy", 32'(occupancy), q.size());
         check("empty", 32'(empty), (q.size() == 0) ? 1 : 0);
         check("wrReady", 32'(wr_ready), exp_ready);
         check("ramWe", 32'(ram_we), (q.size() > 0) ? 1 : 0);
         check("ramAddr", 32'(ram_addr), (q.size() > 0) ? q[0].addr : 0);
         check("ramData", 32'(ram_data), (q.size() > 0) ? q[0].data : 0);
         check("lookupHit", 32'(lookup_hit), exp_hit);
         check("lookupData", 32'(lookup_data), exp_ldata);
      end
      @(posedge clk);
      if (rst) begin
         q.delete();
      end else begin
         if (q.size() > 0) void'(q.pop_front());
         if (exp_ready == 1) begin
            for (int p = 0; p < 4; p++) begin
               if (v[p]) q.push_back('{addr: 32'(a[p*4 +: 4]), data: 32'(d[p*8 +: 8])});
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic idle(input int unsigned n, input logic [3:0] lk);
      for (int unsigned i = 0; i < n; i++) step(1'b0, 4'b0000, 16'h0, 32'h0, lk, 1'b1);
   endtask

   initial begin
      step(1'b1, 4'b1111, 16'h4321, 32'hDEADBEEF, 4'h0, 1'b0);
      step(1'b1, 4'b0000, 16'h0, 32'h0, 4'h0, 1'b1);

      // Single write, one-cycle latency, then empty again.
      step(1'b0, 4'b0001, 16'h0003, 32'h000000A5, 4'h3, 1'b1);
      check("lat1_we", 32'(ram_we), 1);
      check("lat1_addr", 32'(ram_addr), 3);
      check("lat1_data", 32'(ram_data), 32'hA5);
      idle(2, 4'h3);

      // Sparse ports 0,2,3 compact into consecutive slots.
      step(1'b0, 4'b1101, 16'h3200 | 16'h0001, 32'h33220011, 4'h2, 1'b1);
      idle(4, 4'h2);

      // Burst fill: 4, then 7, then held requests ignored until occupancy <= 4.
      step(1'b0, 4'b1111, 16'hBA98, 32'h13121110, 4'h9, 1'b1);
      step(1'b0, 4'b1111, 16'hFEDC, 32'h17161514, 4'hE, 1'b1);
      check("full_ready", 32'(wr_ready), 0);
      for (int i = 0; i < 5; i++) step(1'b0, 4'b1111, 16'h7777, 32'h99887766, 4'h7, 1'b1);
      idle(10, 4'h7);

      // Duplicate address forwarding returns the youngest entry.
      step(1'b0, 4'b0011, 16'h0055, 32'h00002211, 4'h5, 1'b1);
      check("fwd_hit", 32'(lookup_hit), 1);
      check("fwd_data", 32'(lookup_data), 32'h22);
      idle(3, 4'h5);
      check("fwd_miss", 32'(lookup_hit), 0);

      // Random traffic wrapping the pointers several times.
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 4'($urandom_range(1, 15)), 16'($urandom), $urandom, 4'($urandom), 1'b1);
      end
      idle(9, 4'h0);

      // Reset with occupancy 5 and live requests discards everything.
      step(1'b0, 4'b1111, 16'h4321, 32'h44332211, 4'h1, 1'b1);
      step(1'b0, 4'b0011, 16'h0065, 32'h00006655, 4'h6, 1'b1);
      check("pre_reset_occ", 32'(occupancy), 5);
      step(1'b1, 4'b1111, 16'hCBA9, 32'hCCBBAA99, 4'h9, 1'b1);
      check("post_reset_occ", 32'(occupancy), 0);
      check("post_reset_we", 32'(ram_we), 0);
      idle(3, 4'h9);

      for (int i = 0; i < 300; i++) begin
         step(($urandom_range(0, 49) == 0), 4'($urandom), 16'($urandom & 32'h3333),
              $urandom, 4'($urandom & 32'h3), 1'b1);
      end
      idle(10, 4'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ram_write_serializer.md
RAM_WRITE_SERIALIZER -- requirements
Module: ram_write_serializer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, the number of target RAM entries.
REQ-002 SHALL have parameter INDEX, default 4, the RAM address width.
REQ-003 SHALL have parameter WIDTH, default 8, the RAM data width.
REQ-004 SHALL have parameter QDEPTH, default 8, the write-queue entries; a power of two and at least 4.
REQ-005 SHALL have parameter QINDEX, default 3, equal to log2(QDEPTH).
REQ-006 SHALL have port clk  in  1  clock; all state updates on its rising edge.
REQ-007 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-008 SHALL have ports wrValid0_i..wrValid3_i  in  1 each  write-request valid per source port.
REQ-009 SHALL have ports wrAddr0_i..wrAddr3_i  in  INDEX each  write address per source port.
REQ-010 SHALL have ports wrData0_i..wrData3_i  in  WIDTH each  write data per source port.
REQ-011 SHALL have port wrReady_o  out  1  queue can accept up to four requests this cycle.
REQ-012 SHALL have port ramAddrWr_o  out  INDEX  write address to the single RAM write port.
REQ-013 SHALL have port ramWe_o  out  1  RAM write enable.
REQ-014 SHALL have port ramDataWr_o  out  WIDTH  RAM write data.
REQ-015 SHALL have port lookupAddr_i  in  INDEX  forwarding-lookup address.
REQ-016 SHALL have port lookupHit_o  out  1  a pending queued write matches lookupAddr_i.
REQ-017 SHALL have port lookupData_o  out  WIDTH  data of the youngest matching pending write.
REQ-018 SHALL have port occupancy_o  out  QINDEX+1  number of queued entries.
REQ-019 SHALL have port empty_o  out  1  occupancy_o == 0.

Function
REQ-020 SHALL drive wrReady_o = 1 iff (QDEPTH - occupancy) >= 4, using occupancy at cycle start; a same-cycle drain is not credited.
REQ-021 SHALL accept requests only when wrReady_o = 1; requests presented with wrReady_o = 0 are ignored, not latched.
REQ-022 SHALL enqueue accepted valid requests compacted, in port order 0,1,2,3, behind all existing entries; invalid ports consume no slot.
REQ-023 SHALL present the queue head combinationally from registered state: ramWe_o = !empty, ramAddrWr_o/ramDataWr_o = head entry; zeros when empty.
REQ-024 SHALL dequeue the head every cycle in which ramWe_o = 1; there is no RAM-side backpressure.
REQ-025 SHALL make an accepted request visible on the RAM port no earlier than the next cycle; minimum latency is 1 cycle, and it is exactly 1 when the queue is empty.
REQ-026 SHALL update occupancy as occupancy + accepted - dequeued, with accepted in 0..4 and dequeued in 0..1 in the same cycle.
REQ-027 SHALL wrap head and tail pointers modulo QDEPTH.
REQ-028 SHALL never overflow: REQ-020 guarantees occupancy <= QDEPTH.
REQ-029 SHALL evaluate the lookup combinationally over queued entries only, excluding requests arriving this cycle; lookupHit_o = 1 if any match.
REQ-030 SHALL set lookupData_o to the youngest matching entry; lookupData_o = 0 on a miss.
REQ-031 SHALL include the head entry in the lookup during the cycle it is being written to RAM.
REQ-032 SHALL preserve duplicate addresses across or within cycles and issue them in order, with no coalescing.

Reset
REQ-033 SHALL, on reset = 1 at a clock edge, zero the head, tail and occupancy.
REQ-034 SHALL, on reset, discard all pending writes, and SHALL ignore requests presented in that same cycle.
REQ-035 SHALL hold these values after reset: ramWe_o = 0, ramAddrWr_o = 0, ramDataWr_o = 0, lookupHit_o = 0, lookupData_o = 0, occupancy_o = 0, empty_o = 1, wrReady_o = 1.
REQ-036 SHALL NOT reset queue data storage; it is don't-care while its slot is invalid.

Structure
REQ-037 SHALL place a write-request struct {addr [INDEX], data [WIDTH]} and the QDEPTH/QINDEX constants in the shared core package.
REQ-038 SHALL implement the compaction and slot assignment of up to four requests as one sub-module, write_compact4, outputting the count plus per-slot offsets.
REQ-039 SHALL use flop-based storage with no vendor RAM macros.

Verification
REQ-040 SHALL check: reset, then port0 writes addr 3 data 0xA5 with the queue empty -> next cycle ramWe_o = 1, ramAddrWr_o = 3, ramDataWr_o = 0xA5; the cycle after, empty_o = 1.
REQ-041 SHALL check: ports 0,2,3 valid with addrs 1,2,3 in one cycle -> RAM writes addr 1,2,3 on three consecutive cycles; occupancy_o goes 3,2,1,0.
REQ-042 SHALL check: four requests on each of two cycles -> occupancy 4, then 7 (+4 -1); wrReady_o = 0 at 7, and held requests are ignored until occupancy <= 4.
REQ-043 SHALL check: two queued writes to addr 5 with data 0x11 then 0x22, lookupAddr_i = 5 -> lookupHit_o = 1, lookupData_o = 0x22; after both drain, lookupHit_o = 0.
REQ-044 SHALL check: pointer wrap-around over 20 random accepted writes -> RAM sequence matches acceptance order exactly.
REQ-045 SHALL check: reset asserted with occupancy 5 and new requests valid -> next cycle occupancy_o = 0, ramWe_o = 0, and no discarded write ever appears.
